// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle source for the pwm block: debounced push-button stepping plus optional
// auto-ramp, wrapping below PERIOD, with a one-cycle strobe whenever duty changes.
module pwm_duty_ctrl #(
  parameter int DUTY_W         = 10,
  parameter int PERIOD         = 1000,
  parameter int STEP           = 50,
  parameter int WRAP_VALUE     = 1,
  parameter int RAMP_TICKS     = 1000000,
  parameter int DEBOUNCE_TICKS = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key,
  input  logic              ramp_en,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_update,
  output logic              key_pressed,
  output logic              led
);

  localparam int SUM_W  = DUTY_W + 2;
  localparam int DB_W   = $clog2(DEBOUNCE_TICKS);
  localparam int RAMP_W = $clog2(RAMP_TICKS);

  localparam logic [DB_W-1:0]   DB_ZERO    = DB_W'(0);
  localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RAMP_W-1:0] RAMP_ZERO  = RAMP_W'(0);
  localparam logic [RAMP_W-1:0] RAMP_ONE   = RAMP_W'(1);
  localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [SUM_W-1:0]  PERIOD_S   = SUM_W'(PERIOD);
  localparam logic [SUM_W-1:0]  STEP_S     = SUM_W'(STEP);
  localparam logic [SUM_W-1:0]  SUM_ZERO   = SUM_W'(0);
  localparam logic [SUM_W-1:0]  SUM_ONE    = SUM_W'(1);
  localparam logic [DUTY_W-1:0] WRAP_D     = DUTY_W'(WRAP_VALUE);
  localparam logic [DUTY_W-1:0] DUTY_ZERO  = DUTY_W'(0);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  logic              key_meta_r;
  logic              key_sync_r;
  db_state_t         state_r;
  db_state_t         state_next_s;
  logic [DB_W-1:0]   cnt_r;
  logic [DB_W-1:0]   cnt_next_s;
  logic              press_s;
  logic [RAMP_W-1:0] rcnt_r;
  logic [RAMP_W-1:0] rcnt_next_s;
  logic              tick_s;
  logic [DUTY_W-1:0] duty_r;
  logic              duty_update_r;
  logic              key_pressed_r;
  logic              led_r;

  // Sum is widened by two bits so duty+STEP+1 can never overflow before the wrap test.
  function automatic logic [DUTY_W-1:0] duty_step(input logic [DUTY_W-1:0] cur,
                                                  input logic press,
                                                  input logic tick);
    logic [SUM_W-1:0] inc;
    logic [SUM_W-1:0] sum;
    inc = (press ? STEP_S : SUM_ZERO) + (tick ? SUM_ONE : SUM_ZERO);
    sum = {2'b00, cur} + inc;
    if (sum >= PERIOD_S) begin
      return WRAP_D;
    end else begin
      return sum[DUTY_W-1:0];
    end
  endfunction

  // Two-flop synchroniser for the asynchronous key; idles released (high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
    end else begin
      key_meta_r <= key;
      key_sync_r <= key_meta_r;
    end
  end

  // Debounce state and stability counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= RELEASED;
      cnt_r   <= DB_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Debounce next-state: a level is accepted only after DEBOUNCE_TICKS equal samples.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    press_s      = 1'b0;
    case (state_r)
      RELEASED: begin
        if (!key_sync_r) begin
          state_next_s = PRESS_WAIT;
          cnt_next_s   = DB_ONE;
        end else begin
          state_next_s = RELEASED;
        end
      end
      PRESS_WAIT: begin
        if (key_sync_r) begin
          state_next_s = RELEASED;
          cnt_next_s   = DB_ZERO;
        end else if (cnt_r == DB_LAST) begin
          state_next_s = PRESSED;
          cnt_next_s   = DB_ZERO;
          press_s      = 1'b1;
        end else begin
          cnt_next_s   = cnt_r + DB_ONE;
        end
      end
      PRESSED: begin
        if (key_sync_r) begin
          state_next_s = RELEASE_WAIT;
          cnt_next_s   = DB_ONE;
        end else begin
          state_next_s = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (!key_sync_r) begin
          state_next_s = PRESSED;
          cnt_next_s   = DB_ZERO;
        end else if (cnt_r == DB_LAST) begin
          state_next_s = RELEASED;
          cnt_next_s   = DB_ZERO;
        end else begin
          cnt_next_s   = cnt_r + DB_ONE;
        end
      end
      default: begin
        state_next_s = RELEASED;
        cnt_next_s   = DB_ZERO;
      end
    endcase
  end

  // Ramp counter next value; disabling the ramp parks the counter at zero.
  always_comb begin
    tick_s      = 1'b0;
    rcnt_next_s = RAMP_ZERO;
    if (!ramp_en) begin
      rcnt_next_s = RAMP_ZERO;
    end else if (rcnt_r == RAMP_LAST) begin
      tick_s      = 1'b1;
      rcnt_next_s = RAMP_ZERO;
    end else begin
      rcnt_next_s = rcnt_r + RAMP_ONE;
    end
  end

  // Ramp counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rcnt_r <= RAMP_ZERO;
    end else begin
      rcnt_r <= rcnt_next_s;
    end
  end

  // Duty, strobes and LED; press and tick in the same cycle merge into one update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      duty_r        <= DUTY_ZERO;
      duty_update_r <= 1'b0;
      key_pressed_r <= 1'b0;
      led_r         <= 1'b0;
    end else begin
      key_pressed_r <= press_s;
      duty_update_r <= press_s | tick_s;
      if (press_s || tick_s) begin
        duty_r <= duty_step(duty_r, press_s, tick_s);
      end
      if (press_s) begin
        led_r <= ~led_r;
      end
    end
  end

  assign duty        = duty_r;
  assign duty_update = duty_update_r;
  assign key_pressed = key_pressed_r;
  assign led         = led_r;

endmodule
